// File: rtl/hazard_pkg.sv
// Shared state/cause encodings and a mask helper for the N-stage hazard unit.
package hazard_pkg;

   typedef enum logic [1:0] {RUN, SQUASH, REDIR} hz_state_t;

   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_DWAIT,
      CAUSE_SQUASH,
      CAUSE_REDIR,
      CAUSE_REDIRECT,
      CAUSE_LOAD_USE,
      CAUSE_IWAIT
   } hz_cause_t;

   // Bits [n-1:0] set: selects every pipeline register upstream of stage n.
   function automatic logic [7:0] low_mask(input int n);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < n) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/hazard_unit_nstage_if.sv
// Pipeline <-> hazard unit bundle; master is the pipeline datapath, slave is the hazard unit.
interface hazard_unit_nstage_if #(parameter int NSTAGES = 4);
   import hazard_pkg::*;

   logic               iren, i_ram_busy;
   logic               dren, dwen, d_ram_busy;
   logic               jump, branch, mispredict;
   logic [4:0]         dec_rs1, dec_rs2;
   logic               dec_rs1_used, dec_rs2_used;
   logic               ex_valid, ex_load;
   logic [4:0]         ex_rd;
   logic               wb_valid;
   logic [4:0]         wb_rd;
   logic               pc_en, npc_sel;
   logic [NSTAGES-2:0] stall, flush;
   hz_cause_t          stall_cause;

   modport master (
      output iren, i_ram_busy, dren, dwen, d_ram_busy, jump, branch, mispredict,
             dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, ex_valid, ex_load, ex_rd,
             wb_valid, wb_rd,
      input  pc_en, npc_sel, stall, flush, stall_cause
   );

   modport slave (
      input  iren, i_ram_busy, dren, dwen, d_ram_busy, jump, branch, mispredict,
             dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used, ex_valid, ex_load, ex_rd,
             wb_valid, wb_rd,
      output pc_en, npc_sel, stall, flush, stall_cause
   );

endinterface

// File: rtl/load_scoreboard.sv
// Pending-load scoreboard: set by loads leaving EX, cleared at writeback; same-cycle set beats clear.
// Lookup is combinational and treats a register written back this cycle as available.
module load_scoreboard (
   input  logic       CLK,
   input  logic       nRST,
   input  logic       set_en,
   input  logic [4:0] set_rd,
   input  logic       clr_en,
   input  logic [4:0] clr_rd,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       rs1_used,
   input  logic       rs2_used,
   output logic       hazard
);

   logic [31:0] pending;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;
   logic [31:0] live;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && set_rd != 5'd0) set_mask[set_rd] = 1'b1;
      if (clr_en) clr_mask[clr_rd] = 1'b1;
   end

   assign live   = pending & ~clr_mask;
   assign hazard = (rs1_used && rs1 != 5'd0 && live[rs1]) ||
                   (rs2_used && rs2 != 5'd0 && live[rs2]);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pending <= '0;
      end else begin
         pending <= live | set_mask;
      end
   end

endmodule

// File: rtl/hazard_unit_nstage.sv
// Stall/flush/PC control for an N-stage pipeline; same-cycle combinational response from registered state.
// Data-memory wait outranks everything and freezes the redirect FSM so a held redirect is replayed later.
module hazard_unit_nstage
   import hazard_pkg::*;
#(
   parameter int NSTAGES      = 4,
   parameter int DEC_STAGE    = 1,
   parameter int EX_STAGE     = 2,
   parameter int MEM_STAGE    = 2,
   parameter int REDIRECT_LAT = 0
) (
   input logic                 CLK,
   input logic                 nRST,
   hazard_unit_nstage_if.slave bus
);

   localparam int         NR          = NSTAGES - 1;
   localparam bit         HAS_MEM_REG = (MEM_STAGE < NR);
   localparam int         MEM_IDX     = HAS_MEM_REG ? MEM_STAGE : 0;
   localparam bit         HAS_EX_REG  = (EX_STAGE < NR);
   localparam int         EX_IDX      = HAS_EX_REG ? EX_STAGE : 0;
   localparam logic [2:0] LAT         = 3'(REDIRECT_LAT);

   hz_state_t     state;
   logic [2:0]    cnt;
   logic          redirect, dwait, iwait, load_use, ex_adv, sb_set;
   logic          pc_en_c, npc_sel_c;
   logic [NR-1:0] stall_c, flush_c;
   hz_cause_t     cause_c;

   assign redirect = bus.jump | (bus.branch & bus.mispredict);
   assign dwait    = bus.d_ram_busy & (bus.dren | bus.dwen);
   assign iwait    = bus.iren & bus.i_ram_busy;

   // A load only becomes pending once it actually leaves EX.
   assign ex_adv = HAS_EX_REG ? ~(stall_c[EX_IDX] | flush_c[EX_IDX]) : 1'b1;
   assign sb_set = bus.ex_valid & bus.ex_load & ex_adv;

   load_scoreboard u_scoreboard (
      .CLK      (CLK),
      .nRST     (nRST),
      .set_en   (sb_set),
      .set_rd   (bus.ex_rd),
      .clr_en   (bus.wb_valid),
      .clr_rd   (bus.wb_rd),
      .rs1      (bus.dec_rs1),
      .rs2      (bus.dec_rs2),
      .rs1_used (bus.dec_rs1_used),
      .rs2_used (bus.dec_rs2_used),
      .hazard   (load_use)
   );

   always_comb begin
      stall_c   = '0;
      flush_c   = '0;
      pc_en_c   = 1'b0;
      npc_sel_c = 1'b0;
      cause_c   = CAUSE_NONE;
      if (dwait) begin
         stall_c = NR'(low_mask(MEM_STAGE));
         if (HAS_MEM_REG) flush_c[MEM_IDX] = 1'b1;
         cause_c = CAUSE_DWAIT;
      end else if (state == SQUASH) begin
         flush_c[0] = 1'b1;
         cause_c    = CAUSE_SQUASH;
      end else if (state == REDIR) begin
         flush_c[0] = 1'b1;
         cause_c    = CAUSE_REDIR;
      end else if (redirect) begin
         pc_en_c   = 1'b1;
         npc_sel_c = 1'b1;
         flush_c   = NR'(low_mask(EX_STAGE));
         cause_c   = CAUSE_REDIRECT;
      end else if (load_use) begin
         stall_c          = NR'(low_mask(DEC_STAGE));
         flush_c[DEC_STAGE] = 1'b1;
         cause_c          = CAUSE_LOAD_USE;
      end else if (iwait) begin
         flush_c[0] = 1'b1;
         cause_c    = CAUSE_IWAIT;
      end else begin
         pc_en_c = 1'b1;
      end
      flush_c = flush_c & ~stall_c;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= RUN;
         cnt   <= 3'd0;
      end else if (!dwait) begin
         unique case (state)
            SQUASH: begin
               if (!bus.i_ram_busy) begin
                  if (LAT != 3'd0) begin
                     state <= REDIR;
                     cnt   <= LAT;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            REDIR: begin
               if (cnt <= 3'd1) begin
                  state <= RUN;
                  cnt   <= 3'd0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: begin
               if (redirect) begin
                  if (iwait) begin
                     state <= SQUASH;
                  end else if (LAT != 3'd0) begin
                     state <= REDIR;
                     cnt   <= LAT;
                  end
               end
            end
         endcase
      end
   end

   // Reset forces a full bubble everywhere without waiting for a clock.
   assign bus.pc_en       = nRST & pc_en_c;
   assign bus.npc_sel     = nRST & npc_sel_c;
   assign bus.stall       = nRST ? stall_c : '0;
   assign bus.flush       = nRST ? flush_c : '1;
   assign bus.stall_cause = nRST ? cause_c : CAUSE_NONE;

endmodule

// File: tb/tb_hazard_unit_nstage.sv
// Bench for hazard_unit_nstage: two instances (redirect latency 0 and 2) share stimulus and are checked each cycle.
module tb_hazard_unit_nstage;

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_unit_nstage_if #(.NSTAGES(4)) bus_a ();
   hazard_unit_nstage_if #(.NSTAGES(4)) bus_b ();

   hazard_unit_nstage #(.NSTAGES(4), .DEC_STAGE(1), .EX_STAGE(2), .MEM_STAGE(2), .REDIRECT_LAT(0))
      dut_a (.CLK(CLK), .nRST(nRST), .bus(bus_a.slave));
   hazard_unit_nstage #(.NSTAGES(4), .DEC_STAGE(1), .EX_STAGE(2), .MEM_STAGE(2), .REDIRECT_LAT(2))
      dut_b (.CLK(CLK), .nRST(nRST), .bus(bus_b.slave));

   assign bus_b.iren         = bus_a.iren;
   assign bus_b.i_ram_busy   = bus_a.i_ram_busy;
   assign bus_b.dren         = bus_a.dren;
   assign bus_b.dwen         = bus_a.dwen;
   assign bus_b.d_ram_busy   = bus_a.d_ram_busy;
   assign bus_b.jump         = bus_a.jump;
   assign bus_b.branch       = bus_a.branch;
   assign bus_b.mispredict   = bus_a.mispredict;
   assign bus_b.dec_rs1      = bus_a.dec_rs1;
   assign bus_b.dec_rs2      = bus_a.dec_rs2;
   assign bus_b.dec_rs1_used = bus_a.dec_rs1_used;
   assign bus_b.dec_rs2_used = bus_a.dec_rs2_used;
   assign bus_b.ex_valid     = bus_a.ex_valid;
   assign bus_b.ex_load      = bus_a.ex_load;
   assign bus_b.ex_rd        = bus_a.ex_rd;
   assign bus_b.wb_valid     = bus_a.wb_valid;
   assign bus_b.wb_rd        = bus_a.wb_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Model: fetch squash flag, remaining bubble count and a set of pending load targets.
   bit        m_squash [2];
   int        m_bub    [2];
   bit [31:0] m_pend   [2];
   bit        nx_squash[2];
   int        nx_bub   [2];
   bit [31:0] nx_pend  [2];

   task automatic model_cycle(input int d);
      int        lat, st, fl, cause;
      bit        pc, np, redirect, iw, dw, lu;
      bit [31:0] live;
      logic      a_pc, a_np;
      logic [2:0] a_st, a_fl, a_ca;
      lat = (d == 0) ? 0 : 2;
      st = 0; fl = 0; cause = 0; pc = 0; np = 0;
      if (d == 0) begin
         a_pc = bus_a.pc_en; a_np = bus_a.npc_sel; a_st = bus_a.stall; a_fl = bus_a.flush;
         a_ca = bus_a.stall_cause;
      end else begin
         a_pc = bus_b.pc_en; a_np = bus_b.npc_sel; a_st = bus_b.stall; a_fl = bus_b.flush;
         a_ca = bus_b.stall_cause;
      end
      redirect = bus_a.jump | (bus_a.branch & bus_a.mispredict);
      iw = bus_a.iren & bus_a.i_ram_busy;
      dw = bus_a.d_ram_busy & (bus_a.dren | bus_a.dwen);
      live = m_pend[d];
      if (bus_a.wb_valid) live[bus_a.wb_rd] = 1'b0;
      lu = (bus_a.dec_rs1_used && bus_a.dec_rs1 != 5'd0 && live[bus_a.dec_rs1]) ||
           (bus_a.dec_rs2_used && bus_a.dec_rs2 != 5'd0 && live[bus_a.dec_rs2]);
      nx_squash[d] = m_squash[d]; nx_bub[d] = m_bub[d]; nx_pend[d] = m_pend[d];
      if (!nRST) begin
         fl = 7; nx_squash[d] = 0; nx_bub[d] = 0; nx_pend[d] = '0;
      end else begin
         if (dw) begin
            st = 3; fl = 4; cause = 1;
         end else if (m_squash[d]) begin
            fl = 1; cause = 2;
            if (!bus_a.i_ram_busy) begin nx_squash[d] = 0; nx_bub[d] = lat; end
         end else if (m_bub[d] > 0) begin
            fl = 1; cause = 3; nx_bub[d] = m_bub[d] - 1;
         end else if (redirect) begin
            pc = 1; np = 1; fl = 3; cause = 4;
            if (iw) nx_squash[d] = 1; else nx_bub[d] = lat;
         end else if (lu) begin
            st = 1; fl = 2; cause = 5;
         end else if (iw) begin
            fl = 1; cause = 6;
         end else begin
            pc = 1;
         end
         fl = fl & ~st;
         nx_pend[d] = live;
         if (bus_a.ex_valid && bus_a.ex_load && bus_a.ex_rd != 5'd0 && ((st | fl) & 4) == 0)
            nx_pend[d][bus_a.ex_rd] = 1'b1;
      end
      chk($sformatf("model pc_en[%0d]", d),   32'(a_pc), 32'(pc));
      chk($sformatf("model npc_sel[%0d]", d), 32'(a_np), 32'(np));
      chk($sformatf("model stall[%0d]", d),   32'(a_st), st);
      chk($sformatf("model flush[%0d]", d),   32'(a_fl), fl);
      chk($sformatf("model cause[%0d]", d),   32'(a_ca), cause);
   endtask

   always @(negedge CLK) begin
      model_cycle(0);
      model_cycle(1);
   end

   always @(posedge CLK) begin
      for (int d = 0; d < 2; d++) begin
         m_squash[d] <= nx_squash[d];
         m_bub[d]    <= nx_bub[d];
         m_pend[d]   <= nx_pend[d];
      end
   end

   task automatic tick_in(); @(posedge CLK); #1; endtask
   task automatic settle();  @(negedge CLK); #1; endtask

   task automatic idle();
      bus_a.iren = 0; bus_a.i_ram_busy = 0; bus_a.dren = 0; bus_a.dwen = 0; bus_a.d_ram_busy = 0;
      bus_a.jump = 0; bus_a.branch = 0; bus_a.mispredict = 0;
      bus_a.dec_rs1 = 0; bus_a.dec_rs2 = 0; bus_a.dec_rs1_used = 0; bus_a.dec_rs2_used = 0;
      bus_a.ex_valid = 0; bus_a.ex_load = 0; bus_a.ex_rd = 0; bus_a.wb_valid = 0; bus_a.wb_rd = 0;
   endtask

   initial begin
      nRST = 1'b0;
      idle();
      bus_a.d_ram_busy = 1; bus_a.dren = 1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("rst pc_en", 32'(bus_a.pc_en), 0);
         chk("rst flush", 32'(bus_a.flush), 32'h7);
      end
      tick_in(); nRST = 1'b1; bus_a.d_ram_busy = 0; bus_a.dren = 0; settle();
      chk("idle pc_en", 32'(bus_a.pc_en), 1);
      chk("idle flush", 32'(bus_a.flush), 0);

      // Load-use on x5, released by writeback bypass
      tick_in(); bus_a.ex_valid = 1; bus_a.ex_load = 1; bus_a.ex_rd = 5; settle();
      chk("lu pre pc_en", 32'(bus_a.pc_en), 1);
      tick_in(); bus_a.ex_valid = 0; bus_a.ex_load = 0; bus_a.dec_rs1 = 5; bus_a.dec_rs1_used = 1; settle();
      chk("lu stall", 32'(bus_a.stall), 32'h1);
      chk("lu flush", 32'(bus_a.flush), 32'h2);
      chk("lu pc_en", 32'(bus_a.pc_en), 0);
      tick_in(); settle();
      chk("lu stall hold", 32'(bus_a.stall), 32'h1);
      tick_in(); bus_a.wb_valid = 1; bus_a.wb_rd = 5; settle();
      chk("lu wb stall", 32'(bus_a.stall), 0);
      chk("lu wb pc_en", 32'(bus_a.pc_en), 1);
      tick_in(); bus_a.wb_valid = 0; settle();
      chk("lu cleared", 32'(bus_a.stall), 0);

      // Load to x0 never stalls
      tick_in(); idle(); bus_a.ex_valid = 1; bus_a.ex_load = 1; bus_a.ex_rd = 0; settle();
      tick_in(); idle(); bus_a.dec_rs1_used = 1; settle();
      chk("x0 stall", 32'(bus_a.stall), 0);
      chk("x0 pc_en", 32'(bus_a.pc_en), 1);

      // Same-cycle set and clear of x7: set wins
      tick_in(); idle(); bus_a.ex_valid = 1; bus_a.ex_load = 1; bus_a.ex_rd = 7;
      bus_a.wb_valid = 1; bus_a.wb_rd = 7; settle();
      tick_in(); idle(); bus_a.dec_rs2 = 7; bus_a.dec_rs2_used = 1; settle();
      chk("x7 stall", 32'(bus_a.stall), 32'h1);
      chk("x7 cause", 32'(bus_a.stall_cause), 5);
      tick_in(); bus_a.wb_valid = 1; bus_a.wb_rd = 7; settle();
      tick_in(); idle(); settle();

      // Mispredict with stale fetch in flight
      tick_in(); bus_a.branch = 1; bus_a.mispredict = 1; bus_a.iren = 1; bus_a.i_ram_busy = 1; settle();
      chk("mp0 npc_sel", 32'(bus_a.npc_sel), 1);
      chk("mp0 flush", 32'(bus_a.flush), 32'h3);
      tick_in(); bus_a.branch = 0; bus_a.mispredict = 0; settle();
      chk("mp1 flush", 32'(bus_a.flush), 32'h1);
      chk("mp1 pc_en", 32'(bus_a.pc_en), 0);
      chk("mp1 cause", 32'(bus_a.stall_cause), 2);
      tick_in(); settle();
      chk("mp2 npc_sel", 32'(bus_a.npc_sel), 0);
      tick_in(); bus_a.i_ram_busy = 0; bus_a.iren = 0; settle();
      chk("mp3 flush", 32'(bus_a.flush), 32'h1);
      chk("mp3 pc_en", 32'(bus_a.pc_en), 0);
      tick_in(); settle();
      chk("mp4 pc_en", 32'(bus_a.pc_en), 1);
      chk("mp4 lat2 cause", 32'(bus_b.stall_cause), 3);
      tick_in(); settle();
      chk("mp5 lat2 pc_en", 32'(bus_b.pc_en), 0);
      tick_in(); settle();
      chk("mp6 lat2 pc_en", 32'(bus_b.pc_en), 1);

      // Jump with two bubble cycles on the latency-2 instance
      tick_in(); bus_a.jump = 1; settle();
      chk("j0 npc_sel", 32'(bus_b.npc_sel), 1);
      tick_in(); bus_a.jump = 0; settle();
      chk("j1 npc_sel", 32'(bus_b.npc_sel), 0);
      chk("j1 flush", 32'(bus_b.flush), 32'h1);
      chk("j1 pc_en", 32'(bus_b.pc_en), 0);
      tick_in(); settle();
      chk("j2 pc_en", 32'(bus_b.pc_en), 0);
      tick_in(); settle();
      chk("j3 pc_en", 32'(bus_b.pc_en), 1);

      // Data wait holds a mispredict until memory completes
      tick_in(); bus_a.dren = 1; bus_a.d_ram_busy = 1; bus_a.branch = 1; bus_a.mispredict = 1; settle();
      chk("dw0 stall", 32'(bus_a.stall), 32'h3);
      chk("dw0 flush", 32'(bus_a.flush), 32'h4);
      chk("dw0 npc_sel", 32'(bus_a.npc_sel), 0);
      tick_in(); settle();
      chk("dw1 stall", 32'(bus_a.stall), 32'h3);
      tick_in(); bus_a.d_ram_busy = 0; settle();
      chk("dw2 npc_sel", 32'(bus_a.npc_sel), 1);
      tick_in(); idle(); settle();
      tick_in(); settle();
      tick_in(); settle();

      // Reset mid-bubble discards FSM state and the scoreboard
      tick_in(); bus_a.ex_valid = 1; bus_a.ex_load = 1; bus_a.ex_rd = 9; settle();
      tick_in(); idle(); bus_a.jump = 1; settle();
      tick_in(); idle(); nRST = 1'b0; settle();
      chk("mr rst flush", 32'(bus_b.flush), 32'h7);
      tick_in(); nRST = 1'b1; bus_a.dec_rs1 = 9; bus_a.dec_rs1_used = 1; settle();
      chk("mr pc_en", 32'(bus_b.pc_en), 1);
      chk("mr stall", 32'(bus_b.stall), 0);

      // Mixed traffic, checked only by the model
      for (int c = 0; c < 400; c++) begin
         tick_in();
         nRST               = ($urandom_range(0, 79) != 0);
         bus_a.iren         = 1'($urandom_range(0, 1));
         bus_a.i_ram_busy   = ($urandom_range(0, 2) == 0);
         bus_a.dren         = ($urandom_range(0, 3) == 0);
         bus_a.dwen         = ($urandom_range(0, 5) == 0);
         bus_a.d_ram_busy   = ($urandom_range(0, 2) == 0);
         bus_a.jump         = ($urandom_range(0, 15) == 0);
         bus_a.branch       = ($urandom_range(0, 7) == 0);
         bus_a.mispredict   = 1'($urandom_range(0, 1));
         bus_a.dec_rs1      = 5'($urandom_range(0, 7));
         bus_a.dec_rs2      = 5'($urandom_range(0, 7));
         bus_a.dec_rs1_used = 1'($urandom_range(0, 1));
         bus_a.dec_rs2_used = 1'($urandom_range(0, 1));
         bus_a.ex_valid     = 1'($urandom_range(0, 1));
         bus_a.ex_load      = 1'($urandom_range(0, 1));
         bus_a.ex_rd        = 5'($urandom_range(0, 7));
         bus_a.wb_valid     = 1'($urandom_range(0, 1));
         bus_a.wb_rd        = 5'($urandom_range(0, 7));
         settle();
      end

      tick_in();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
